// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round functions and FSM state type for the
// self-sequencing compression engine.
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, PASS1, FIN1, PASS2, FIN2} state_e;

  localparam logic [2047:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Tail of the second-pass block: a 256-bit message is padded to 512 bits.
  localparam logic [255:0] SHA256_PAD2 = {32'h80000000, 192'h0, 32'h00000100};

  // Word 0 sits in the top bits, so word idx starts at bit (63-idx)*32.
  function automatic logic [31:0] k_word(input logic [5:0] idx);
    return K_ROM[{~idx, 5'b00000} +: 32];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round over the packed {a..h} state.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] state_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_i;
  assign t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k_i + w_i;
  assign t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
  assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_engine.sv
// Self-sequencing SHA-256 compression engine with unrolled rounds and an
// optional second pass over the first digest (double SHA-256).
module sha256_engine
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter bit          DOUBLE_EN        = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         double_i,
  input  logic [511:0] m_i,
  input  logic [255:0] h_in_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [255:0] h_out_o
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;
  localparam logic [6:0] ROUND_STEP = 7'(R);
  localparam logic [6:0] LAST_ROUND = 7'(64 - R);

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("sha256_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_e       state_q;
  logic         busy_q, done_q, double_q;
  logic [6:0]   round_q;
  logic [255:0] hin_q, work_q, hout_q;
  logic [31:0]  w_q [16];

  logic [255:0] work_d, d1;
  logic [511:0] blk2;
  logic [31:0]  w_d [16];

  // Window holds W[t..t+15]; words past it are expanded for this cycle's rounds.
  for (genvar i = 0; i < 16 + R; i++) begin : g_w
    logic [31:0] word;
    if (i < 16) begin : g_win
      assign word = w_q[i];
    end else begin : g_exp
      assign word = small_sigma1(g_w[i-2].word) + g_w[i-7].word
                  + small_sigma0(g_w[i-15].word) + g_w[i-16].word;
    end
  end

  for (genvar j = 0; j < 16; j++) begin : g_slide
    assign w_d[j] = g_w[j+R].word;
  end

  for (genvar r = 0; r < R; r++) begin : g_rnd
    logic [255:0] st_in, st_out;
    if (r == 0) begin : g_first
      assign st_in = work_q;
    end else begin : g_next
      assign st_in = g_rnd[r-1].st_out;
    end
    sha256_round u_round (
      .state_i (st_in),
      .k_i     (k_word(6'(round_q[5:0] + 6'(r)))),
      .w_i     (g_w[r].word),
      .state_o (st_out)
    );
  end

  assign work_d = g_rnd[R-1].st_out;
  assign d1     = add_words(hin_q, work_q);
  assign blk2   = {d1, SHA256_PAD2};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      double_q <= 1'b0;
      round_q  <= '0;
      hin_q    <= '0;
      work_q   <= '0;
      hout_q   <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            hin_q    <= h_in_i;
            double_q <= double_i;
            work_q   <= h_in_i;
            for (int i = 0; i < 16; i++) w_q[i] <= m_i[511-32*i -: 32];
            round_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= PASS1;
          end
        end
        PASS1, PASS2: begin
          work_q  <= work_d;
          for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
          round_q <= round_q + ROUND_STEP;
          if (round_q == LAST_ROUND) state_q <= (state_q == PASS1) ? FIN1 : FIN2;
        end
        FIN1: begin
          round_q <= '0;
          if (DOUBLE_EN && double_q) begin
            work_q  <= SHA256_IV;
            for (int i = 0; i < 16; i++) w_q[i] <= blk2[511-32*i -: 32];
            state_q <= PASS2;
          end else begin
            hout_q  <= d1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        FIN2: begin
          round_q <= '0;
          hout_q  <= add_words(SHA256_IV, work_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign h_out_o = hout_q;

endmodule
